car_detect: RTL and testbench
=============================

// Module: car_detect
// PURPOSE
//  Conditions the raw Prospect Ave loop-sensor input into the car_present request consumed by Stoplight.
//  Synchronises and debounces the sensor, latches a request until Prospect is served (green seen on light_pros).
//  Reports last wait time and a sticky stuck-sensor fault. Sits directly upstream of Stoplight.
// PARAMETERS
//  DB_CYCLES    4    consecutive mismatching samples required to change the debounced level (>=1)
//  CNT_W        8    width of wait_cycles counter
//  STUCK_CYCLES 200  consecutive cycles of sensor_db=1 that raise sensor_fault (>=1)
// PORTS
//  clk          in   1      system clock, all state on rising edge
//  rst          in   1      asynchronous, active-low reset (0 = reset asserted)
//  sensor_raw   in   1      raw loop sensor, asynchronous to clk, 1 = metal detected
//  light_pros   in   3      Prospect light from Stoplight; bit0 red, bit1 yellow, bit2 green
//  car_present  out  1      latched service request to Stoplight
//  sensor_db    out  1      synchronised, debounced sensor level
//  wait_cycles  out  CNT_W  cycles spent in REQ for current/last request, saturating
//  sensor_fault out  1      sticky: sensor held high STUCK_CYCLES consecutive cycles
// BEHAVIOUR
//  Reset (rst=0, async): sync flops, sensor_db, debounce/stuck counters, wait_cycles, sensor_fault = 0; state = IDLE.
//  Sync: two-flop synchroniser s1<=sensor_raw, s2<=s1. No logic between s1 and s2.
//  Debounce: each edge, if s2!=sensor_db, db_cnt++; else db_cnt<=0. On the edge where s2!=sensor_db and
//   db_cnt==DB_CYCLES-1: sensor_db<=s2, db_cnt<=0. Raw high sampled at edge 0 -> sensor_db=1 after edge
//   DB_CYCLES+1 (edge 5 at default). Any single agreeing sample restarts the count (glitch rejected).
//  GRN is exactly light_pros==3'b100; any other code (incl. 000, multi-hot) is treated as not green.
//  FSM (Moore; car_present = (state==REQ), decoded from state register, no extra latency):
//   IDLE : sensor_db=1 -> REQ; else stay.
//   REQ  : GRN -> SERVE; else stay. Request is latched: sensor_db falling does NOT cancel it.
//   SERVE: !GRN -> (sensor_db ? REQ : IDLE); else stay. car_present=0 throughout SERVE.
//   Illegal state encodings -> IDLE next edge.
//  Simultaneous: in SERVE, green dropping while sensor_db=1 -> REQ on same edge (queued car re-requests).
//  wait_cycles: loaded to 0 on every edge entering REQ; +1 each edge spent in REQ; saturates at 2^CNT_W-1;
//   holds value in IDLE and SERVE (last wait visible until next request).
//  Stuck detect: st_cnt++ each edge sensor_db=1 (saturating at STUCK_CYCLES), st_cnt<=0 when sensor_db=0.
//   sensor_fault<=1 on edge st_cnt reaches STUCK_CYCLES; cleared only by reset. Fault does not gate
//   car_present (fail-safe: intersection keeps cycling).
//  Reset mid-request: car_present drops asynchronously with rst=0; resumes only after new debounced detection.
// TESTING
//  1 rst=0 then release, sensor_raw=0, light_pros=001 -> all outputs 0 for 50 cycles.
//  2 sensor_raw 0->1 sampled at edge 0 -> sensor_db=1 after edge 5, car_present=1 after edge 6;
//    hold light_pros=001 for 10 more cycles -> wait_cycles=10.
//  3 sensor_raw 3-cycle pulse (DB_CYCLES=4) -> sensor_db and car_present never assert.
//  4 in REQ drop sensor_raw, keep light_pros=001 -> car_present stays 1; light_pros=100 -> car_present=0
//    next edge; light_pros=010 with sensor_db=0 -> IDLE, wait_cycles holds.
//  5 in SERVE with sensor_db=1, light_pros 100->010 -> car_present=1 next edge, wait_cycles restarts at 0.
//  6 sensor_raw held 1, light_pros=001 -> sensor_fault=1 STUCK_CYCLES edges after sensor_db rises;
//    wait_cycles saturates at 255; sensor_raw=0 -> fault stays 1 until rst=0.

Source files
------------

// File: rtl/car_detect_if.sv
// Sensor/light bundle between the loop-sensor conditioner and its environment.
// master drives the raw sensor and the Prospect light; slave is the conditioner.
interface car_detect_if #(
  parameter int CNT_W = 8
);
  logic             sensor_raw;
  logic [2:0]       light_pros;
  logic             car_present;
  logic             sensor_db;
  logic [CNT_W-1:0] wait_cycles;
  logic             sensor_fault;

  modport master (
    output sensor_raw, light_pros,
    input  car_present, sensor_db, wait_cycles, sensor_fault
  );

  modport slave (
    input  sensor_raw, light_pros,
    output car_present, sensor_db, wait_cycles, sensor_fault
  );
endinterface

// File: rtl/car_detect.sv
// Prospect Ave loop-sensor conditioner: synchronise, debounce, latch a service
// request until Prospect turns green, time the wait, and flag a stuck sensor.
module car_detect #(
  parameter int DB_CYCLES    = 4,
  parameter int CNT_W        = 8,
  parameter int STUCK_CYCLES = 200
) (
  input  logic        clk,
  input  logic        rst,
  car_detect_if.slave bus
);

  localparam int DB_W = $clog2(DB_CYCLES + 1);
  localparam int ST_W = $clog2(STUCK_CYCLES + 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);
  localparam logic [ST_W-1:0]  ST_MAX   = ST_W'(STUCK_CYCLES);
  localparam logic [ST_W-1:0]  ST_LAST  = ST_W'(STUCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    REQ   = 2'b01,
    SERVE = 2'b10
  } state_t;

  logic             s1;
  logic             s2;
  logic             sensor_db;
  logic [DB_W-1:0]  db_cnt;
  logic [ST_W-1:0]  st_cnt;
  logic             sensor_fault;
  logic [CNT_W-1:0] wait_cnt;
  state_t           state;
  state_t           state_next;
  logic             grn;

  // Only the exact one-hot green code counts; dark or multi-hot codes are not green.
  assign grn = (bus.light_pros == 3'b100);

  // Two-flop synchroniser for the asynchronous loop sensor.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= bus.sensor_raw;
      s2 <= s1;
    end
  end

  // Debounce: the level flips only after DB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sensor_db <= 1'b0;
      db_cnt    <= '0;
    end else if (s2 != sensor_db) begin
      if (db_cnt == DB_LAST) begin
        sensor_db <= s2;
        db_cnt    <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // Stuck-sensor detector: saturating run length of sensor_db=1, sticky fault.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_cnt       <= '0;
      sensor_fault <= 1'b0;
    end else if (!sensor_db) begin
      st_cnt <= '0;
    end else if (st_cnt != ST_MAX) begin
      st_cnt <= st_cnt + 1'b1;
      if (st_cnt == ST_LAST) sensor_fault <= 1'b1;
    end
  end

  // Request FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Request FSM next state: request latches until green, re-requests if a car is queued.
  // NOTE: the default assignment first keeps this block purely combinational (no latch).
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = sensor_db ? REQ : IDLE;
      REQ:     state_next = grn ? SERVE : REQ;
      SERVE:   state_next = grn ? SERVE : (sensor_db ? REQ : IDLE);
      default: state_next = IDLE;
    endcase
  end

  // Wait timer: cleared on entry to REQ, counts every cycle in REQ, holds otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (state_next == REQ && state != REQ) begin
      wait_cnt <= '0;
    end else if (state == REQ && wait_cnt != WAIT_MAX) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign bus.car_present  = (state == REQ);
  assign bus.sensor_db    = sensor_db;
  assign bus.wait_cycles  = wait_cnt;
  assign bus.sensor_fault = sensor_fault;

endmodule

// File: tb/tb_car_detect.sv
// Self-checking bench for car_detect: directed scenarios followed by random
// sensor/light traffic, all compared every cycle against a behavioural model.
module tb_car_detect;

  localparam int DB_CYCLES    = 4;
  localparam int CNT_W        = 8;
  localparam int STUCK_CYCLES = 200;
  localparam int WAIT_MAX     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  car_detect_if #(.CNT_W(CNT_W)) bus ();

  car_detect #(
    .DB_CYCLES   (DB_CYCLES),
    .CNT_W       (CNT_W),
    .STUCK_CYCLES(STUCK_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: raw samples travel through a 2-deep delay queue; the
  // debounced level follows after DB_CYCLES disagreeing samples in a row;
  // a request is "waiting" until green, then "served" until green ends.
  bit m_pipe[$];
  bit m_db;
  int m_run;
  bit m_waiting;
  bit m_served;
  int m_wait;
  int m_high;
  bit m_fault;

  task automatic model_reset();
    m_pipe    = {1'b0, 1'b0};
    m_db      = 1'b0;
    m_run     = 0;
    m_waiting = 1'b0;
    m_served  = 1'b0;
    m_wait    = 0;
    m_high    = 0;
    m_fault   = 1'b0;
  endtask

  task automatic model_edge();
    bit sync_now;
    bit db_old;
    bit green;
    bit was_waiting;
    bit now_waiting;
    bit now_served;
    if (!rst) begin
      model_reset();
      return;
    end
    sync_now    = m_pipe[0];
    db_old      = m_db;
    green       = (bus.light_pros == 3'b100);
    was_waiting = m_waiting;
    // synchroniser delay
    void'(m_pipe.pop_front());
    m_pipe.push_back(bus.sensor_raw);
    // debounce
    if (sync_now != m_db) begin
      m_run++;
      if (m_run == DB_CYCLES) begin
        m_db  = sync_now;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    // request latch
    now_waiting = m_waiting;
    now_served  = m_served;
    if (m_waiting) begin
      if (green) begin now_waiting = 1'b0; now_served = 1'b1; end
    end else if (m_served) begin
      if (!green) begin now_served = 1'b0; now_waiting = db_old; end
    end else begin
      now_waiting = db_old;
    end
    // wait timer
    if (now_waiting && !was_waiting) m_wait = 0;
    else if (was_waiting)             m_wait = (m_wait < WAIT_MAX) ? m_wait + 1 : WAIT_MAX;
    m_waiting = now_waiting;
    m_served  = now_served;
    // stuck detection
    if (db_old) begin
      if (m_high < STUCK_CYCLES) m_high++;
      if (m_high == STUCK_CYCLES) m_fault = 1'b1;
    end else begin
      m_high = 0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".car_present"},  32'(bus.car_present),  32'(m_waiting));
    check({tag, ".sensor_db"},    32'(bus.sensor_db),    32'(m_db));
    check({tag, ".wait_cycles"},  32'(bus.wait_cycles),  32'(m_wait));
    check({tag, ".sensor_fault"}, 32'(bus.sensor_fault), 32'(m_fault));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  // Assert reset mid-cycle, verify outputs clear without a clock edge, then release.
  task automatic apply_reset(input int cycles);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    repeat (cycles) tick("in_rst");
    #3 rst = 1'b1;
  endtask

  logic [2:0] light_codes [8];
  int         hold_wait;

  initial begin
    light_codes = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b000, 3'b110, 3'b101, 3'b111};
    model_reset();
    rst            = 1'b1;
    bus.sensor_raw = 1'b0;
    bus.light_pros = 3'b001;
    #1 rst = 1'b0;
    #1;
    check_outputs("power_on_rst");
    repeat (3) tick("in_rst");
    #3 rst = 1'b1;

    // 1: idle for 50 cycles
    repeat (50) tick("idle");
    check("idle_car_present", 32'(bus.car_present), 32'd0);
    check("idle_wait", 32'(bus.wait_cycles), 32'd0);

    // 2: detection latency and wait timing
    bus.sensor_raw = 1'b1;
    repeat (5) tick("detect");
    check("db_before_edge5", 32'(bus.sensor_db), 32'd0);
    tick("detect");
    check("db_at_edge5", 32'(bus.sensor_db), 32'd1);
    check("cp_at_edge5", 32'(bus.car_present), 32'd0);
    tick("detect");
    check("cp_at_edge6", 32'(bus.car_present), 32'd1);
    check("wait_at_entry", 32'(bus.wait_cycles), 32'd0);
    repeat (10) tick("req_wait");
    check("wait_after_10", 32'(bus.wait_cycles), 32'd10);

    // 4: request stays latched after the car leaves, green serves it
    bus.sensor_raw = 1'b0;
    repeat (8) tick("latched");
    check("latched_cp", 32'(bus.car_present), 32'd1);
    check("latched_db", 32'(bus.sensor_db), 32'd0);
    bus.light_pros = 3'b100;
    tick("serve");
    check("serve_cp", 32'(bus.car_present), 32'd0);
    hold_wait      = m_wait;
    bus.light_pros = 3'b010;
    repeat (3) tick("to_idle");
    check("idle_cp", 32'(bus.car_present), 32'd0);
    check("wait_holds", 32'(bus.wait_cycles), 32'(hold_wait));

    // 3: a 3-cycle glitch never reaches the debounced level
    bus.light_pros = 3'b001;
    bus.sensor_raw = 1'b1;
    repeat (3) tick("glitch");
    bus.sensor_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick("glitch");
      check("glitch_db", 32'(bus.sensor_db), 32'd0);
    end
    check("glitch_cp", 32'(bus.car_present), 32'd0);

    // 5: green ending with a queued car re-requests immediately
    bus.sensor_raw = 1'b1;
    repeat (8) tick("req2");
    check("req2_cp", 32'(bus.car_present), 32'd1);
    bus.light_pros = 3'b100;
    tick("serve2");
    check("serve2_cp", 32'(bus.car_present), 32'd0);
    bus.light_pros = 3'b010;
    tick("rerequest");
    check("rerequest_cp", 32'(bus.car_present), 32'd1);
    check("rerequest_wait", 32'(bus.wait_cycles), 32'd0);

    // 6: stuck sensor, wait saturation, sticky fault
    bus.light_pros = 3'b001;
    repeat (300) tick("stuck");
    check("stuck_fault", 32'(bus.sensor_fault), 32'd1);
    check("wait_saturated", 32'(bus.wait_cycles), 32'(WAIT_MAX));
    bus.sensor_raw = 1'b0;
    repeat (10) tick("fault_sticky");
    check("fault_sticky", 32'(bus.sensor_fault), 32'd1);
    apply_reset(2);
    check("fault_cleared", 32'(bus.sensor_fault), 32'd0);

    // Random traffic: sensor runs of varying length, arbitrary light codes, rare resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) bus.sensor_raw = ~bus.sensor_raw;
      if ($urandom_range(0, 11) == 0) bus.light_pros = light_codes[$urandom_range(0, 7)];
      if ($urandom_range(0, 999) == 0) apply_reset(1);
      tick("random");
    end
    bus.sensor_raw = 1'b1;
    bus.light_pros = 3'b001;
    repeat (260) tick("random_stuck");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
